// File: rtl/x_string_delay_line_pkg.sv
// Shared types for the x-digit delay line: multiplier FSM state encoding and the
// signed-digit pair layout.
package x_string_delay_line_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_ITER = 2'b01,
    ST_LOAD = 2'b10,
    ST_HOLD = 2'b11
  } mult_state_e;

  localparam int unsigned DigitW = 4;

  typedef struct packed {
    logic [DigitW-1:0] plus;
    logic [DigitW-1:0] minus;
  } sd_digit_t;

endpackage

// File: rtl/x_string_delay_line_if.sv
// Digit-source side bundle of the x-digit delay line: controls, digit in, selected digit out.
interface x_string_delay_line_if #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned SEL_W   = 3
);
  logic               write_enable;
  logic               flush;
  logic [1:0]         STATES;
  logic [SEL_W-1:0]   delay_sel;
  logic [DIGIT_W-1:0] x_plus;
  logic [DIGIT_W-1:0] x_minus;
  logic [DIGIT_W-1:0] x_plus_value;
  logic [DIGIT_W-1:0] x_minus_value;
  logic               value_valid;
  logic [SEL_W-1:0]   fill_cnt;

  modport master (
    output write_enable, flush, STATES, delay_sel, x_plus, x_minus,
    input  x_plus_value, x_minus_value, value_valid, fill_cnt
  );

  modport slave (
    input  write_enable, flush, STATES, delay_sel, x_plus, x_minus,
    output x_plus_value, x_minus_value, value_valid, fill_cnt
  );
endinterface

// File: rtl/x_string_delay_line_sd_digit_stage.sv
// One plus/minus digit register pair of the delay line; clear wins over load.
module x_string_delay_line_sd_digit_stage #(
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [DIGIT_W-1:0] plus_i,
  input  logic [DIGIT_W-1:0] minus_i,
  output logic [DIGIT_W-1:0] plus_o,
  output logic [DIGIT_W-1:0] minus_o
);
  logic [DIGIT_W-1:0] plus_d, plus_q;
  logic [DIGIT_W-1:0] minus_d, minus_q;

  always_comb begin
    plus_d  = plus_q;
    minus_d = minus_q;
    if (clr_i) begin
      plus_d  = '0;
      minus_d = '0;
    end else if (en_i) begin
      plus_d  = plus_i;
      minus_d = minus_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      plus_q  <= '0;
      minus_q <= '0;
    end else begin
      plus_q  <= plus_d;
      minus_q <= minus_d;
    end
  end

  assign plus_o  = plus_q;
  assign minus_o = minus_q;
endmodule

// File: rtl/x_string_delay_line.sv
// Programmable-depth delay line for the redundant x digit string; presents either the
// current digit or a delayed tap, chosen from the multiplier state and the last-write state.
module x_string_delay_line
  import x_string_delay_line_pkg::*;
#(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned MAX_DELAY = 4,
  parameter int unsigned NORMALISE = 1,
  localparam int unsigned SEL_W    = $clog2(MAX_DELAY + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  x_string_delay_line_if.slave bus_io
);
  localparam logic [SEL_W-1:0] MaxSel = SEL_W'(MAX_DELAY);

  logic [DIGIT_W-1:0] din_p, din_m;
  logic [DIGIT_W-1:0] stage_in_p [MAX_DELAY];
  logic [DIGIT_W-1:0] stage_in_m [MAX_DELAY];
  logic [DIGIT_W-1:0] stage_p    [MAX_DELAY];
  logic [DIGIT_W-1:0] stage_m    [MAX_DELAY];

  logic [1:0]         prev_state_d, prev_state_q;
  logic [SEL_W-1:0]   fill_cnt_d, fill_cnt_q;
  logic [SEL_W-1:0]   sel;
  logic               use_delayed;
  logic [DIGIT_W-1:0] tap_p, tap_m;
  logic [DIGIT_W-1:0] out_p_d, out_p_q, out_m_d, out_m_q;
  logic               valid_d, valid_q;

  // Overlapping plus/minus bits cancel to a zero digit position.
  always_comb begin
    if (NORMALISE != 0) begin
      din_p = bus_io.x_plus & ~bus_io.x_minus;
      din_m = bus_io.x_minus & ~bus_io.x_plus;
    end else begin
      din_p = bus_io.x_plus;
      din_m = bus_io.x_minus;
    end
  end

  for (genvar i = 0; i < MAX_DELAY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in_p[i] = din_p;
      assign stage_in_m[i] = din_m;
    end else begin : g_tail
      assign stage_in_p[i] = stage_p[i-1];
      assign stage_in_m[i] = stage_m[i-1];
    end

    x_string_delay_line_sd_digit_stage #(
      .DIGIT_W (DIGIT_W)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (bus_io.write_enable),
      .clr_i   (bus_io.flush),
      .plus_i  (stage_in_p[i]),
      .minus_i (stage_in_m[i]),
      .plus_o  (stage_p[i]),
      .minus_o (stage_m[i])
    );
  end

  assign sel = (bus_io.delay_sel > MaxSel) ? MaxSel : bus_io.delay_sel;

  assign use_delayed = (sel != '0) &&
                       ((bus_io.STATES == ST_INIT) ||
                        ((bus_io.STATES == ST_ITER) && (prev_state_q == ST_LOAD)));

  // Tap reads the pre-shift contents, so a same-cycle write never leaks into the output.
  always_comb begin
    tap_p = '0;
    tap_m = '0;
    for (int unsigned i = 0; i < MAX_DELAY; i++) begin
      if (sel == SEL_W'(i + 1)) begin
        tap_p = stage_p[i];
        tap_m = stage_m[i];
      end
    end
  end

  always_comb begin
    prev_state_d = prev_state_q;
    fill_cnt_d   = fill_cnt_q;
    out_p_d      = din_p;
    out_m_d      = din_m;
    valid_d      = 1'b1;
    if (bus_io.flush) begin
      prev_state_d = ST_INIT;
      fill_cnt_d   = '0;
      out_p_d      = '0;
      out_m_d      = '0;
      valid_d      = 1'b0;
    end else begin
      if (bus_io.write_enable) begin
        prev_state_d = bus_io.STATES;
        if (fill_cnt_q != MaxSel) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      if (use_delayed) begin
        out_p_d = tap_p;
        out_m_d = tap_m;
        valid_d = (fill_cnt_q >= sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_state_q <= ST_INIT;
      fill_cnt_q   <= '0;
      out_p_q      <= '0;
      out_m_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      fill_cnt_q   <= fill_cnt_d;
      out_p_q      <= out_p_d;
      out_m_q      <= out_m_d;
      valid_q      <= valid_d;
    end
  end

  assign bus_io.x_plus_value  = out_p_q;
  assign bus_io.x_minus_value = out_m_q;
  assign bus_io.value_valid   = valid_q;
  assign bus_io.fill_cnt      = fill_cnt_q;
endmodule

// File: tb/tb_x_string_delay_line.sv
// Scoreboard bench for x_string_delay_line (DIGIT_W=4, MAX_DELAY=4, NORMALISE=1).
module tb_x_string_delay_line;
  import x_string_delay_line_pkg::*;

  typedef struct {
    sd_digit_t val;
    logic      valid;
    string     tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  exp_t        exp_q [$];
  sd_digit_t   hist  [$];
  int unsigned m_fill;
  logic [1:0]  m_prev;

  x_string_delay_line_if #(.DIGIT_W(4), .SEL_W(3)) bus ();

  x_string_delay_line #(
    .DIGIT_W   (4),
    .MAX_DELAY (4),
    .NORMALISE (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // Drive one cycle, predict the registered output, then compare it after the edge.
  task automatic step(input logic we, input logic fl, input logic [1:0] st,
                      input logic [2:0] sel, input logic [3:0] p, input logic [3:0] m,
                      input string tag);
    sd_digit_t   din;
    exp_t        e;
    int unsigned s;
    logic        use_d;
    din.plus  = p & ~m;
    din.minus = m & ~p;
    s = (sel > 3'd4) ? 4 : int'(sel);
    use_d = (s != 0) && (st == ST_INIT || (st == ST_ITER && m_prev == ST_LOAD));
    e.tag = tag;
    if (fl) begin
      e.val = '0;
      e.valid = 1'b0;
    end else if (use_d) begin
      e.val = (hist.size() >= int'(s)) ? hist[s-1] : '0;
      e.valid = (m_fill >= s);
    end else begin
      e.val = din;
      e.valid = 1'b1;
    end
    bus.write_enable = we;
    bus.flush        = fl;
    bus.STATES       = st;
    bus.delay_sel    = sel;
    bus.x_plus       = p;
    bus.x_minus      = m;
    exp_q.push_back(e);
    @(posedge clk);
    if (fl) begin
      hist.delete();
      m_fill = 0;
      m_prev = ST_INIT;
    end else if (we) begin
      hist.push_front(din);
      if (hist.size() > 4) void'(hist.pop_back());
      if (m_fill < 4) m_fill++;
      m_prev = st;
    end
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({bus.x_plus_value, bus.x_minus_value, bus.value_valid} !==
        {e.val.plus, e.val.minus, e.valid}) begin
      errors++;
      $display("FAIL %s: got p=%h m=%h v=%b, want p=%h m=%h v=%b", e.tag,
               bus.x_plus_value, bus.x_minus_value, bus.value_valid,
               e.val.plus, e.val.minus, e.valid);
    end
    checks++;
    if (bus.fill_cnt !== 3'(m_fill)) begin
      errors++;
      $display("FAIL %s_fill: got %0d, want %0d", e.tag, bus.fill_cnt, m_fill);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.write_enable = 1'($urandom);
    bus.flush        = 1'($urandom);
    bus.STATES       = 2'($urandom);
    bus.delay_sel    = 3'($urandom);
    bus.x_plus       = 4'($urandom);
    bus.x_minus      = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.value_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, want 0", bus.value_valid);
    end
    checks++;
    if ({bus.x_plus_value, bus.x_minus_value} !== 8'h00) begin
      errors++;
      $display("FAIL reset_value: got %h/%h, want 0/0", bus.x_plus_value, bus.x_minus_value);
    end
    checks++;
    if (bus.fill_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_fill: got %0d, want 0", bus.fill_cnt);
    end
    hist.delete();
    m_fill = 0;
    m_prev = ST_INIT;
    rst_n  = 1'b1;
  endtask

  task automatic test_bypass();
    step(1'b0, 1'b0, ST_INIT, 3'd0, 4'hA, 4'h5, "bypass_a5");
    checks++;
    if ({bus.x_plus_value, bus.x_minus_value, bus.value_valid} !== {4'hA, 4'h5, 1'b1}) begin
      errors++;
      $display("FAIL bypass_const: got %h/%h v=%b, want a/5 v=1",
               bus.x_plus_value, bus.x_minus_value, bus.value_valid);
    end
  endtask

  task automatic test_delay2();
    step(1'b1, 1'b0, ST_INIT, 3'd2, 4'h1, 4'h0, "d2_w1");
    checks++;
    if (bus.value_valid !== 1'b0) begin
      errors++;
      $display("FAIL d2_fill1_valid: got %b, want 0", bus.value_valid);
    end
    step(1'b1, 1'b0, ST_INIT, 3'd2, 4'h2, 4'h0, "d2_w2");
    checks++;
    if (bus.value_valid !== 1'b0) begin
      errors++;
      $display("FAIL d2_fill2_valid: got %b, want 0", bus.value_valid);
    end
    step(1'b1, 1'b0, ST_INIT, 3'd2, 4'h3, 4'h0, "d2_w3");
    step(1'b0, 1'b0, ST_INIT, 3'd2, 4'h0, 4'h0, "d2_read");
    checks++;
    if ({bus.x_plus_value, bus.value_valid} !== {4'h2, 1'b1}) begin
      errors++;
      $display("FAIL d2_const: got p=%h v=%b, want p=2 v=1", bus.x_plus_value, bus.value_valid);
    end
  endtask

  task automatic test_prev_state();
    step(1'b1, 1'b0, ST_LOAD, 3'd1, 4'h5, 4'h0, "ps_load_write");
    step(1'b0, 1'b0, ST_ITER, 3'd1, 4'hF, 4'h0, "ps_iter_delayed");
    checks++;
    if ({bus.x_plus_value, bus.value_valid} !== {4'h5, 1'b1}) begin
      errors++;
      $display("FAIL ps_delayed_const: got p=%h v=%b, want p=5 v=1",
               bus.x_plus_value, bus.value_valid);
    end
    step(1'b0, 1'b0, ST_HOLD, 3'd1, 4'h7, 4'h0, "ps_hold_bypass");
    step(1'b1, 1'b0, ST_ITER, 3'd1, 4'h6, 4'h0, "ps_iter_write");
    step(1'b0, 1'b0, ST_ITER, 3'd1, 4'h9, 4'h0, "ps_iter_bypass");
    checks++;
    if (bus.x_plus_value !== 4'h9) begin
      errors++;
      $display("FAIL ps_bypass_const: got p=%h, want p=9", bus.x_plus_value);
    end
  endtask

  task automatic test_normalise();
    step(1'b0, 1'b0, ST_HOLD, 3'd0, 4'b1100, 4'b0110, "norm_bypass");
    checks++;
    if ({bus.x_plus_value, bus.x_minus_value} !== {4'b1000, 4'b0010}) begin
      errors++;
      $display("FAIL norm_bypass_const: got %b/%b, want 1000/0010",
               bus.x_plus_value, bus.x_minus_value);
    end
    step(1'b1, 1'b0, ST_INIT, 3'd0, 4'b1100, 4'b0110, "norm_write");
    step(1'b0, 1'b0, ST_INIT, 3'd1, 4'h0, 4'h0, "norm_stored");
    checks++;
    if ({bus.x_plus_value, bus.x_minus_value} !== {4'b1000, 4'b0010}) begin
      errors++;
      $display("FAIL norm_stored_const: got %b/%b, want 1000/0010",
               bus.x_plus_value, bus.x_minus_value);
    end
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, ST_INIT, 3'd0, 4'(i), 4'h0, "fl_fill");
    end
    checks++;
    if (bus.fill_cnt !== 3'd4) begin
      errors++;
      $display("FAIL fl_full: got %0d, want 4", bus.fill_cnt);
    end
    step(1'b0, 1'b0, ST_INIT, 3'd7, 4'h0, 4'h0, "fl_clamp");
    checks++;
    if ({bus.x_plus_value, bus.value_valid} !== {4'h1, 1'b1}) begin
      errors++;
      $display("FAIL fl_clamp_const: got p=%h v=%b, want p=1 v=1",
               bus.x_plus_value, bus.value_valid);
    end
    step(1'b1, 1'b1, ST_INIT, 3'd4, 4'hF, 4'h0, "fl_flush");
    checks++;
    if ({bus.fill_cnt, bus.value_valid, bus.x_plus_value} !== {3'd0, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL fl_flush_const: got fill=%0d v=%b p=%h, want fill=0 v=0 p=0",
               bus.fill_cnt, bus.value_valid, bus.x_plus_value);
    end
    step(1'b0, 1'b0, ST_INIT, 3'd1, 4'h0, 4'h0, "fl_discard");
    checks++;
    if ({bus.x_plus_value, bus.value_valid} !== {4'h0, 1'b0}) begin
      errors++;
      $display("FAIL fl_discard_const: got p=%h v=%b, want p=0 v=0",
               bus.x_plus_value, bus.value_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom), 3'($urandom),
           4'($urandom), 4'($urandom), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_delay2();
    test_prev_state();
    test_normalise();
    test_flush();
    test_back_to_back();
    test_reset();
    step(1'b0, 1'b0, ST_INIT, 3'd2, 4'h3, 4'h0, "post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
